input_port_ctrl: RTL
====================

// Module: input_port_ctrl
// PURPOSE
// - One per router input (16 instances). Deserialises the 4-bit destination address, buffers the serial payload,
//   and raises a one-hot request to the per-output fixed-priority arbiters.
// - Holds the request until grant, then streams the payload to the 16x16 crosspoint. Sits directly upstream of the
//   arbiters: request_out[d] wires to request[PORT_ID] of output d's arbiter; grant_in[d] is that arbiter's grant[PORT_ID].
// PARAMETERS
// - PORT_ID    0    index of this input in every arbiter (0 = highest priority); used only for assertions
// - FIFO_DEPTH 64   payload buffer, in bits; power of two, >= 8
// - PAD_CYCLES 5    fixed padding cycles between address and payload
// PORTS
// - clock        in  1   sole clock, all logic on posedge
// - reset        in  1   synchronous, active-high
// - din          in  1   serial input data
// - frame_in     in  1   high for the whole packet; falling edge marks the last payload bit
// - valid_in     in  1   payload bit on din is valid (ignored during address/pad)
// - request_out  out 16  one-hot request to output arbiters
// - grant_in     in  16  grant bit for this input from each output arbiter
// - dout         out 1   serial data to crosspoint
// - valid_out    out 1   dout valid
// - frame_out    out 1   high from the first forwarded bit through the last forwarded bit
// - busy         out 1   high from address capture until DONE exits; sender must not start a new frame while high
// - overflow     out 1   sticky error: payload bit arrived with FIFO full (bit dropped); cleared only by reset
// BEHAVIOUR
// - Reset: all outputs 0; FSM = IDLE; FIFO empty; address register 0.
// - FSM states: IDLE, ADDR, PAD, RECV_WAIT, FWD, DONE.
//   - IDLE -> ADDR on frame_in=1. That cycle's din is addr[0].
//   - ADDR: capture din LSB-first into addr[3:0] over 4 cycles total (including the IDLE->ADDR cycle), then -> PAD.
//   - PAD: count PAD_CYCLES, ignoring din/valid_in. On exit, request_out <= (1<<addr), registered.
//   - RECV_WAIT: push din to FIFO when valid_in=1. -> FWD in the cycle after grant_in[addr]=1 is sampled.
//   - FWD: pop 1 bit/cycle while FIFO non-empty and grant held; dout/valid_out registered (1-cycle pop->out latency).
//     Pushes continue concurrently. -> DONE when the input frame has ended (frame_in fell) AND the FIFO is empty.
//   - DONE: request_out <= 0, frame_out <= 0 for one cycle, busy <= 0; -> IDLE.
// - request_out stays one-hot and constant from PAD exit to DONE. It never changes while awaiting grant
//   (the arbiter grants with 1-cycle latency and holds the grant while the request is held).
// - Only grant_in[addr] is observed; other grant bits are ignored. Grant loss during FWD (must not occur):
//   pause popping, keep request_out, resume on regrant.
// - FIFO empty mid-FWD while frame_in=1: valid_out=0, frame_out stays 1 (gap); no state change.
// - Packet end: last payload bit = valid bit in the cycle before frame_in falls; a frame_in fall during ADDR/PAD
//   aborts: request never raised, -> IDLE.
// - FIFO full and valid_in=1: bit dropped, overflow <= 1, packet still completes.
// - Simultaneous push and pop: both occur; occupancy unchanged. Pointers wrap modulo FIFO_DEPTH;
//   occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
// - Reset mid-packet: same as power-up reset; request_out drops the next edge, which releases the arbiter.
// CONFIGURATION
// - IPC_PKT_STATS_EN defined: adds outputs pkt_count[15:0] (+1 in each DONE cycle) and drop_count[15:0]
//   (+1 per dropped bit). Both saturate at 16'hFFFF and reset to 0.
// - IPC_PKT_STATS_EN undefined: neither the ports nor the counters exist; all other behaviour is identical.
// STRUCTURE
// - Shared package router_pkg: NUM_PORTS=16, ADDR_W=4, FSM state enum ipc_state_t.
// - One sub-module: bit_fifo (synchronous single-clock FIFO: push, pop, full, empty, dout).
//   FSM and address/pad counters stay in input_port_ctrl.
// TESTING
// - Addr 4'b0101 (din 1,0,1,0), 5 pad, 8 payload bits, grant 2 cycles after request
//   -> request_out=16'h0020; frame_out/valid_out carry the 8 bits in order; request_out=0 in DONE.
// - Grant withheld 20 cycles, 16-bit payload -> all 16 bits buffered, forwarded back-to-back once granted; overflow=0.
// - FIFO_DEPTH=8, 12-bit payload, no grant -> overflow=1 after 9th bit; 8 bits forwarded; drop_count=4 with IPC_PKT_STATS_EN.
// - frame_in drops during PAD -> request_out never asserted; busy=0 within 1 cycle; next packet to addr 15
//   -> request_out=16'h8000.
// - reset=1 during FWD -> next cycle all outputs 0, FIFO empty; a subsequent packet completes normally.
// - valid_in gaps (1 valid bit every 3 cycles) with grant already held -> valid_out gaps; frame_out stays high; no duplicates.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: router-wide constants and the input-port FSM state type.
package router_pkg;
    localparam int NUM_PORTS = 16;
    localparam int ADDR_W    = 4;
    typedef enum logic [2:0] {IDLE, ADDR, PAD, RECV_WAIT, FWD, DONE} ipc_state_t;
endpackage

// File: rtl/input_port_ctrl_if.sv
// input_port_ctrl_if: serial packet, arbiter request/grant and crosspoint signals of one router input.
// IPC_PKT_STATS_EN adds the packet and drop counters.
interface input_port_ctrl_if;
    import router_pkg::*;
    logic                 din;
    logic                 frame_in;
    logic                 valid_in;
    logic [NUM_PORTS-1:0] request_out;
    logic [NUM_PORTS-1:0] grant_in;
    logic                 dout;
    logic                 valid_out;
    logic                 frame_out;
    logic                 busy;
    logic                 overflow;
`ifdef IPC_PKT_STATS_EN
    logic [15:0]          pkt_count;
    logic [15:0]          drop_count;
`endif
    modport slave (
        input  din, frame_in, valid_in, grant_in,
        output request_out, dout, valid_out, frame_out, busy, overflow
`ifdef IPC_PKT_STATS_EN
        , pkt_count, drop_count
`endif
    );
    modport master (
        output din, frame_in, valid_in, grant_in,
        input  request_out, dout, valid_out, frame_out, busy, overflow
`ifdef IPC_PKT_STATS_EN
        , pkt_count, drop_count
`endif
    );
endinterface

// File: rtl/input_port_ctrl_bit_fifo.sv
// bit_fifo: single-clock 1-bit-wide FIFO; caller never pushes when full nor pops when empty.
module bit_fifo #(
    parameter int DEPTH = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
        end
    end
    // DEPTH is a power of two, so the count MSB alone means full
    assign full_o  = cnt_q[PW];
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rd_q];
endmodule

// File: rtl/input_port_ctrl.sv
// input_port_ctrl: router input port; captures the destination address, buffers the payload and
// requests/streams it to one output. IPC_PKT_STATS_EN adds pkt_count/drop_count.
module input_port_ctrl
    import router_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 64,
    parameter int PAD_CYCLES = 5
) (
    input logic              clock,
    input logic              reset,
    input_port_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(PAD_CYCLES > 4 ? PAD_CYCLES : 4) + 1;
    localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_CYCLES - 1);

    ipc_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] req_q, req_d;
    logic dout_q, dout_d, valid_q, valid_d, frame_q, frame_d;
    logic busy_q, busy_d, ovf_q, ovf_d, ended_q, ended_d;
    logic in_rx, ended, push_req, push, pop, drop, full, empty, fifo_dout, grant;

    assign grant    = bus.grant_in[addr_q];
    assign in_rx    = state_q == RECV_WAIT || state_q == FWD;
    assign ended    = ended_q | ~bus.frame_in;
    assign push_req = in_rx & bus.frame_in & bus.valid_in & ~ended_q;
    assign push     = push_req & ~full;
    assign drop     = push_req & full;
    assign pop      = state_q == FWD & grant & ~empty;

    bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (bus.din),
        .dout_o (fifo_dout),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        dout_d  = pop ? fifo_dout : dout_q;
        valid_d = pop;
        frame_d = frame_q | pop;
        busy_d  = busy_q;
        ovf_d   = ovf_q | drop;
        ended_d = ended_q | (in_rx & ~bus.frame_in);
        case (state_q)
            IDLE: begin
                ended_d = 1'b0;
                if (bus.frame_in) begin
                    state_d   = ADDR;
                    addr_d[0] = bus.din;
                    cnt_d     = CNT_W'(1);
                    busy_d    = 1'b1;
                end
            end
            ADDR: begin
                if (!bus.frame_in) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    addr_d[cnt_q[1:0]] = bus.din;
                    cnt_d              = cnt_q + CNT_W'(1);
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = PAD;
                        cnt_d   = '0;
                    end
                end
            end
            PAD: begin
                if (!bus.frame_in) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == PAD_LAST) begin
                        state_d = RECV_WAIT;
                        req_d   = NUM_PORTS'(1) << addr_q;
                    end
                end
            end
            RECV_WAIT: state_d = grant ? FWD : RECV_WAIT;
            FWD: begin
                // last bit already left on dout; drop request and frame as DONE is entered
                if (ended && empty) begin
                    state_d = DONE;
                    req_d   = '0;
                    frame_d = 1'b0;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            ended_q <= ended_d;
        end
    end

    assign bus.request_out = req_q;
    assign bus.dout        = dout_q;
    assign bus.valid_out   = valid_q;
    assign bus.frame_out   = frame_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = ovf_q;

`ifdef IPC_PKT_STATS_EN
    logic [15:0] pkt_q, drop_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (state_q == DONE && pkt_q != 16'hFFFF) pkt_q <= pkt_q + 16'd1;
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end
    assign bus.pkt_count  = pkt_q;
    assign bus.drop_count = drop_q;
`endif

    always_ff @(posedge clock)
        if (!reset) assert ($onehot0(req_q)) else $error("input %0d: request not one-hot", PORT_ID);
endmodule
